// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
// Lines are 4 x 32 bits. The data and tag arrays are synchronous-read RAMs;
// valid/dirty live in flop vectors so INIT can clear one index per cycle.
// Core side: a request accepted at an edge is looked up in the following
// COMPARE cycle. A hit answers in that cycle, and the next request can be
// accepted on the same edge. A miss raises stall until the line is refilled.
// DRAM side handshake: mem_req_valid rises with the request fields and keeps
// them stable until an edge where mem_req_ready is high. That edge completes
// the transfer. A fetch is answered by a single mem_rvalid pulse carrying the
// line. mem_rvalid is ignored outside REFILL_WAIT.
module dcache #(
  parameter int ADDR_LEN   = 25,
  parameter int TAG_LEN    = 9,
  parameter int INDEX_LEN  = 14,
  parameter int OFFSET_LEN = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_LEN-1:0]            req_addr,
  input  logic                           req_re,
  input  logic                           req_we,
  input  logic [31:0]                    req_wdata,
  output logic [31:0]                    rdata,
  output logic                           rdata_valid,
  output logic                           stall,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_we,
  output logic [ADDR_LEN-OFFSET_LEN-1:0] mem_req_addr,
  output logic [127:0]                   mem_req_wdata,
  input  logic                           mem_rvalid,
  input  logic [127:0]                   mem_rdata,
  output logic [2:0]                     dbg_state
);

  localparam int NUM_LINES = 1 << INDEX_LEN;

  localparam logic [2:0] S_INIT        = 3'd0;
  localparam logic [2:0] S_IDLE        = 3'd1;
  localparam logic [2:0] S_COMPARE     = 3'd2;
  localparam logic [2:0] S_WRITEBACK   = 3'd3;
  localparam logic [2:0] S_REFILL      = 3'd4;
  localparam logic [2:0] S_REFILL_WAIT = 3'd5;
  localparam logic [2:0] S_RESPOND     = 3'd6;

  // Storage
  logic [127:0]         data_mem [NUM_LINES];
  logic [TAG_LEN-1:0]   tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // Control and request registers
  logic [2:0]            state_q, state_d;
  logic [INDEX_LEN-1:0]  init_cnt_q;
  logic [TAG_LEN-1:0]    req_tag_q;
  logic [INDEX_LEN-1:0]  req_idx_q;
  logic [OFFSET_LEN-1:0] req_off_q;
  logic                  req_we_q;
  logic [31:0]           req_wdata_q;
  logic [127:0]          data_rd_q;
  logic [TAG_LEN-1:0]    tag_rd_q;
  logic                  fwd_valid_q;
  logic [OFFSET_LEN-1:0] fwd_off_q;
  logic [31:0]           fwd_data_q;
  logic [127:0]          victim_line_q;
  logic [TAG_LEN-1:0]    victim_tag_q;
  logic [31:0]           resp_word_q;

  // Incoming request fields
  logic [OFFSET_LEN-1:0] new_off;
  logic [INDEX_LEN-1:0]  new_idx;
  logic [TAG_LEN-1:0]    new_tag;

  assign new_off = req_addr[OFFSET_LEN-1:0];
  assign new_idx = req_addr[OFFSET_LEN +: INDEX_LEN];
  assign new_tag = req_addr[OFFSET_LEN+INDEX_LEN +: TAG_LEN];

  logic         in_compare;
  logic         hit;
  logic         miss;
  logic         victim_dirty;
  logic         accept;
  logic         write_hit;
  logic         fill;
  logic [127:0] line_eff;
  logic [127:0] fill_line;

  assign in_compare   = (state_q == S_COMPARE);
  assign hit          = valid_q[req_idx_q] && (tag_rd_q == req_tag_q);
  assign miss         = in_compare && !hit;
  assign victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];
  assign write_hit    = in_compare && hit && req_we_q;
  assign fill         = (state_q == S_REFILL_WAIT) && mem_rvalid;
  assign accept       = (req_re || req_we) && !stall &&
                        (state_q == S_IDLE || state_q == S_COMPARE || state_q == S_RESPOND);

  // A store hitting in the previous COMPARE is invisible to the RAM read issued
  // on the same edge, so patch that word into the line seen by COMPARE.
  always_comb begin
    line_eff = data_rd_q;
    if (fwd_valid_q) line_eff[{fwd_off_q, 5'd0} +: 32] = fwd_data_q;
  end

  // Fetched line with the pending store word merged in
  always_comb begin
    fill_line = mem_rdata;
    if (req_we_q) fill_line[{req_off_q, 5'd0} +: 32] = req_wdata_q;
  end

  // Core-side outputs, all derived from registered state
  always_comb begin
    stall       = 1'b0;
    rdata       = 32'd0;
    rdata_valid = 1'b0;
    case (state_q)
      S_INIT, S_WRITEBACK, S_REFILL, S_REFILL_WAIT: stall = 1'b1;
      S_COMPARE: begin
        stall = !hit;
        if (hit && !req_we_q) begin
          rdata       = line_eff[{req_off_q, 5'd0} +: 32];
          rdata_valid = 1'b1;
        end
      end
      S_RESPOND: begin
        if (!req_we_q) begin
          rdata       = resp_word_q;
          rdata_valid = 1'b1;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  // DRAM request outputs; zero whenever no request is outstanding
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (state_q == S_WRITEBACK) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = {victim_tag_q, req_idx_q};
      mem_req_wdata = victim_line_q;
    end else if (state_q == S_REFILL) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {req_tag_q, req_idx_q};
    end
  end

  assign dbg_state = state_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:        if (&init_cnt_q) state_d = S_IDLE;
      S_IDLE:        if (accept) state_d = S_COMPARE;
      S_COMPARE: begin
        if (!hit)        state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
        else if (accept) state_d = S_COMPARE;
        else             state_d = S_IDLE;
      end
      S_WRITEBACK:   if (mem_req_ready) state_d = S_REFILL;
      S_REFILL:      if (mem_req_ready) state_d = S_REFILL_WAIT;
      S_REFILL_WAIT: if (mem_rvalid) state_d = S_RESPOND;
      S_RESPOND:     state_d = accept ? S_COMPARE : S_IDLE;
      default:       state_d = S_INIT;
    endcase
  end

  // FSM, request capture, forwarding, victim and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      req_off_q     <= '0;
      req_we_q      <= 1'b0;
      req_wdata_q   <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_off_q     <= '0;
      fwd_data_q    <= '0;
      victim_line_q <= '0;
      victim_tag_q  <= '0;
      resp_word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (accept) begin
        req_tag_q   <= new_tag;
        req_idx_q   <= new_idx;
        req_off_q   <= new_off;
        req_we_q    <= req_we;
        req_wdata_q <= req_wdata;
        fwd_valid_q <= write_hit && (new_idx == req_idx_q);
        fwd_off_q   <= req_off_q;
        fwd_data_q  <= req_wdata_q;
      end
      if (miss) begin
        victim_line_q <= line_eff;
        victim_tag_q  <= tag_rd_q;
      end
      if (fill) resp_word_q <= fill_line[{req_off_q, 5'd0} +: 32];
    end
  end

  // Data/tag RAMs: synchronous read on accept, word write on store hit, line write on fill
  always_ff @(posedge clk) begin
    if (accept) begin
      data_rd_q <= data_mem[new_idx];
      tag_rd_q  <= tag_mem[new_idx];
    end
    if (write_hit) data_mem[req_idx_q][{req_off_q, 5'd0} +: 32] <= req_wdata_q;
    if (fill) begin
      data_mem[req_idx_q] <= fill_line;
      tag_mem[req_idx_q]  <= req_tag_q;
    end
  end

  // Valid/dirty bits: swept clear during INIT, updated on store hit and fill
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      valid_q[init_cnt_q] <= 1'b0;
      dirty_q[init_cnt_q] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[req_idx_q] <= 1'b1;
    end else if (fill) begin
      valid_q[req_idx_q] <= 1'b1;
      dirty_q[req_idx_q] <= req_we_q;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache with a 16-line configuration.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dcache;

  localparam int AW = 25;
  localparam int LW = 23;

  logic          clk;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic          req_re;
  logic          req_we;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          stall;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [LW-1:0] mem_req_addr;
  logic [127:0]  mem_req_wdata;
  logic          mem_rvalid;
  logic [127:0]  mem_rdata;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  dcache #(.ADDR_LEN(25), .TAG_LEN(19), .INDEX_LEN(4), .OFFSET_LEN(2)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_re(req_re), .req_we(req_we), .req_wdata(req_wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_req();
    req_re = 1'b0; req_we = 1'b0;
  endtask

  task automatic drive_load(input logic [AW-1:0] a);
    req_addr = a; req_re = 1'b1; req_we = 1'b0;
  endtask

  task automatic drive_store(input logic [AW-1:0] a, input logic [31:0] d);
    req_addr = a; req_we = 1'b1; req_re = 1'b0; req_wdata = d;
  endtask

  // Called at the negedge right after reset release; counts stalled cycles
  task automatic measure_init(input string tag);
    int cycles = 0;
    while (stall && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, "_len"}, cycles, 16);
    check({tag, "_done_stall"}, stall, 0);
  endtask

  // Called at a negedge in WRITEBACK/REFILL; holds ready low for 'delay'
  // cycles, then accepts; returns at the following negedge
  task automatic serve_req(input string tag, input logic exp_we, input logic [LW-1:0] exp_addr,
                           input logic [127:0] exp_wdata, input int delay);
    for (int i = 0; i <= delay; i++) begin
      mem_req_ready = (i == delay);
      check({tag, "_valid"}, mem_req_valid, 1);
      check({tag, "_we"}, mem_req_we, exp_we);
      check({tag, "_addr"}, mem_req_addr, exp_addr);
      if (exp_we) check({tag, "_wdata"}, mem_req_wdata, exp_wdata);
      check({tag, "_stall"}, stall, 1);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
  endtask

  // Called at the first REFILL_WAIT negedge; returns at the RESPOND negedge
  task automatic give_line(input string tag, input logic [127:0] line);
    check({tag, "_wait_stall"}, stall, 1);
    check({tag, "_wait_valid"}, mem_req_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = line;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    rst = 1'b0;
    req_addr = '0; req_re = 1'b0; req_we = 1'b0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_stall", stall, 1);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_we", mem_req_we, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_mem_wdata", mem_req_wdata, 0);

    // INIT sweep
    rst = 1'b1;
    measure_init("init");

    // Clean read miss: line 0x41, 4 cycles from capture to rdata
    drive_load(25'h000104);
    @(negedge clk);                               // COMPARE
    idle_req();
    check("miss0_stall", stall, 1);
    check("miss0_rvalid", rdata_valid, 0);
    @(negedge clk);                               // REFILL
    serve_req("fetch0", 1'b0, 23'h000041, '0, 0);
    give_line("fetch0", {32'h4, 32'h3, 32'h2, 32'h1});
    check("miss0_rdata", rdata, 32'h1);           // RESPOND
    check("miss0_rdata_valid", rdata_valid, 1);
    check("miss0_resp_stall", stall, 0);

    // Back-to-back hits, captured from RESPOND
    drive_load(25'h000105);
    @(negedge clk);
    check("hit1_rdata", rdata, 32'h2);
    check("hit1_valid", rdata_valid, 1);
    check("hit1_stall", stall, 0);
    drive_load(25'h000107);
    @(negedge clk);
    check("hit3_rdata", rdata, 32'h4);

    // Store hit then load of the same word on the next edge
    drive_store(25'h000104, 32'hDEADBEEF);
    @(negedge clk);
    check("st_hit_stall", stall, 0);
    check("st_hit_rvalid", rdata_valid, 0);
    drive_load(25'h000104);
    @(negedge clk);
    check("fwd_rdata", rdata, 32'hDEADBEEF);
    check("fwd_valid", rdata_valid, 1);
    check("fwd_stall", stall, 0);
    drive_load(25'h000105);
    @(negedge clk);
    check("after_fwd_rdata", rdata, 32'h2);
    idle_req();
    @(negedge clk);

    // Dirty eviction with 5 cycles of backpressure on the writeback
    drive_load(25'h010104);
    @(negedge clk);                               // COMPARE
    idle_req();
    check("miss1_stall", stall, 1);
    @(negedge clk);                               // WRITEBACK
    serve_req("wb1", 1'b1, 23'h000041, {32'h4, 32'h3, 32'h2, 32'hDEADBEEF}, 5);
    serve_req("fetch1", 1'b0, 23'h004041, '0, 0);
    give_line("fetch1", {32'h40, 32'h30, 32'h20, 32'h10});
    check("miss1_rdata", rdata, 32'h10);
    check("miss1_rdata_valid", rdata_valid, 1);

    // Store miss: fetched line with the store word merged
    drive_store(25'h000108, 32'h55);
    @(negedge clk);                               // COMPARE
    idle_req();
    check("miss2_stall", stall, 1);
    @(negedge clk);                               // REFILL (index 2 is clean)
    serve_req("fetch2", 1'b0, 23'h000042, '0, 0);
    give_line("fetch2", {32'hD, 32'hC, 32'hB, 32'hA});
    check("miss2_resp_rvalid", rdata_valid, 0);
    check("miss2_resp_stall", stall, 0);
    drive_load(25'h000108);
    @(negedge clk);
    check("merge_w0", rdata, 32'h55);
    drive_load(25'h000109);
    @(negedge clk);
    check("merge_w1", rdata, 32'hB);
    idle_req();
    @(negedge clk);

    // Reset while a fetch request is being held off
    drive_load(25'h00010C);
    @(negedge clk);                               // COMPARE
    idle_req();
    @(negedge clk);                               // REFILL, ready low
    check("rr_valid_a", mem_req_valid, 1);
    check("rr_addr", mem_req_addr, 23'h000043);
    @(negedge clk);
    check("rr_valid_b", mem_req_valid, 1);
    rst = 1'b0;
    #1;
    check("rr_drop_valid", mem_req_valid, 0);
    check("rr_drop_addr", mem_req_addr, 0);
    check("rr_stall", stall, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1;                            // stray pulse, must be ignored
    mem_rdata  = {4{32'hFFFFFFFF}};
    measure_init("reinit");
    @(negedge clk);
    check("stray_rvalid_out", rdata_valid, 0);
    check("stray_stall", stall, 0);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Index 2 was dirty before reset; now invalid, so no writeback
    drive_load(25'h010108);
    @(negedge clk);                               // COMPARE
    idle_req();
    check("miss3_stall", stall, 1);
    @(negedge clk);
    serve_req("fetch3", 1'b0, 23'h004042, '0, 0);
    give_line("fetch3", {32'h1D, 32'h1C, 32'h1B, 32'h1A});
    check("miss3_rdata", rdata, 32'h1A);
    check("miss3_rdata_valid", rdata_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
